// File: rtl/fpnew_special_result_pipe.sv
// Pipelined generator of IEEE-754 special-case results. It produces canonical NaN,
// signed infinity, signed zero and signed max-normal for any EXP_BITS/MAN_BITS format,
// boxes the result into an FLEN-wide slot, and raises the matching status flags.
// Results pass through NUM_PIPE_REGS elastic stages with a valid/ready handshake,
// so they can merge into the same output stage as the FMA pipeline.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   flush_i               synchronous kill of every in-flight entry
//   in_valid_i/in_ready_o request handshake
//   kind_i                0=NaN, 1=Inf, 2=Zero, 3=MaxNorm
//   use_sign_i, sign_i    requested sign (ignored for NaN)
//   tag_i / tag_o         opaque pass-through tag
//   out_valid_o/out_ready_i result handshake
//   result_o              boxed FLEN-wide result
//   status_o              {NV,DZ,OF,UF,NX}
//   busy_o                any stage holds a valid entry
module fpnew_special_result_pipe #(
    parameter int unsigned EXP_BITS      = 8,
    parameter int unsigned MAN_BITS      = 23,
    parameter int unsigned FLEN          = 64,
    parameter int unsigned NAN_BOX       = 1,
    parameter int unsigned NUM_PIPE_REGS = 2,
    parameter int unsigned TAG_WIDTH     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [1:0]           kind_i,
    input  logic                 use_sign_i,
    input  logic                 sign_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [FLEN-1:0]      result_o,
    output logic [4:0]           status_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic                 busy_o
);

    localparam int unsigned W = 1 + EXP_BITS + MAN_BITS;

    logic            sgn;
    logic [W-1:0]    enc;
    logic [4:0]      enc_status;
    logic [FLEN-1:0] boxed;

    // Encoding and boxing happen before the first register stage.
    always_comb begin
        sgn        = use_sign_i & sign_i;
        enc        = '0;
        enc_status = '0;
        unique case (kind_i)
            2'd0: begin
                // Canonical quiet NaN is always positive.
                enc        = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MAN_BITS-1){1'b0}}};
                enc_status = 5'b10000;
            end
            2'd1: enc = {sgn, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
            2'd2: enc = {sgn, {EXP_BITS{1'b0}}, {MAN_BITS{1'b0}}};
            2'd3: begin
                enc        = {sgn, {(EXP_BITS-1){1'b1}}, 1'b0, {MAN_BITS{1'b1}}};
                enc_status = 5'b00101;
            end
            default: ;
        endcase
        boxed        = (NAN_BOX != 0) ? {FLEN{1'b1}} : {FLEN{1'b0}};
        boxed[W-1:0] = enc;
    end

    if (NUM_PIPE_REGS == 0) begin : g_comb
        assign in_ready_o  = out_ready_i && !flush_i;
        assign out_valid_o = in_valid_i && !flush_i;
        assign result_o    = boxed;
        assign status_o    = enc_status;
        assign tag_o       = tag_i;
        assign busy_o      = 1'b0;
    end else begin : g_pipe
        localparam int unsigned N = NUM_PIPE_REGS;

        logic [N-1:0]         valid_q;
        logic [N-1:0]         valid_d;
        logic [N-1:0]         adv;
        logic [FLEN-1:0]      result_q [N];
        logic [4:0]           status_q [N];
        logic [TAG_WIDTH-1:0] tag_q    [N];
        logic                 accept;
        logic                 down_ok;
        logic                 stage_adv;

        // Walk from the output back: a stage moves when it is valid and the stage
        // below is empty or moving, which makes bubbles collapse.
        always_comb begin
            adv       = '0;
            down_ok   = out_ready_i;
            stage_adv = 1'b0;
            for (int k = int'(N) - 1; k >= 0; k--) begin
                stage_adv = valid_q[k] && down_ok;
                adv[k]    = stage_adv;
                down_ok   = !valid_q[k] || stage_adv;
            end
        end

        assign in_ready_o = !flush_i && (!valid_q[0] || adv[0]);
        assign accept     = in_valid_i && in_ready_o;

        always_comb begin
            valid_d    = '0;
            valid_d[0] = accept || (valid_q[0] && !adv[0]);
            for (int k = 1; k < int'(N); k++) begin
                valid_d[k] = adv[k-1] || (valid_q[k] && !adv[k]);
            end
            if (flush_i) begin
                valid_d = '0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= '0;
                for (int k = 0; k < int'(N); k++) begin
                    result_q[k] <= '0;
                    status_q[k] <= '0;
                    tag_q[k]    <= '0;
                end
            end else begin
                valid_q <= valid_d;
                if (accept) begin
                    result_q[0] <= boxed;
                    status_q[0] <= enc_status;
                    tag_q[0]    <= tag_i;
                end
                for (int k = 1; k < int'(N); k++) begin
                    if (adv[k-1]) begin
                        result_q[k] <= result_q[k-1];
                        status_q[k] <= status_q[k-1];
                        tag_q[k]    <= tag_q[k-1];
                    end
                end
            end
        end

        assign out_valid_o = valid_q[N-1];
        assign result_o    = result_q[N-1];
        assign status_o    = status_q[N-1];
        assign tag_o       = tag_q[N-1];
        assign busy_o      = |valid_q;
    end

endmodule

// File: tb/tb_fpnew_special_result_pipe.sv
module tb_fpnew_special_result_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance with default parameters (single precision boxed in 64 bits, 2 stages)
    logic        flush, in_valid, in_ready, use_sign, sign, out_valid, out_ready, busy;
    logic [1:0]  kind;
    logic [3:0]  tag, tag_out;
    logic [63:0] result;
    logic [4:0]  status;

    // Double-precision, purely combinational instance
    logic        d_flush, d_in_valid, d_in_ready, d_use_sign, d_sign, d_out_valid;
    logic        d_out_ready, d_busy;
    logic [1:0]  d_kind;
    logic [3:0]  d_tag, d_tag_out;
    logic [63:0] d_result;
    logic [4:0]  d_status;

    fpnew_special_result_pipe #(
        .EXP_BITS(8), .MAN_BITS(23), .FLEN(64), .NAN_BOX(1), .NUM_PIPE_REGS(2), .TAG_WIDTH(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .kind_i(kind), .use_sign_i(use_sign), .sign_i(sign),
        .tag_i(tag), .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
        .status_o(status), .tag_o(tag_out), .busy_o(busy)
    );

    fpnew_special_result_pipe #(
        .EXP_BITS(11), .MAN_BITS(52), .FLEN(64), .NAN_BOX(1), .NUM_PIPE_REGS(0), .TAG_WIDTH(4)
    ) dut_dp (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(d_flush), .in_valid_i(d_in_valid),
        .in_ready_o(d_in_ready), .kind_i(d_kind), .use_sign_i(d_use_sign), .sign_i(d_sign),
        .tag_i(d_tag), .out_valid_o(d_out_valid), .out_ready_i(d_out_ready),
        .result_o(d_result), .status_o(d_status), .tag_o(d_tag_out), .busy_o(d_busy)
    );

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  st;
        logic [3:0]  tg;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   out_cnt = 0;
    bit   mon_en = 1'b0;

    function automatic exp_t model(logic [1:0] k, logic us, logic s, logic [3:0] t);
        exp_t e;
        logic sg;
        sg   = us & s;
        e.tg = t;
        e.st = 5'b00000;
        case (k)
            2'd0: begin e.res = 64'hFFFFFFFF_7FC00000; e.st = 5'b10000; end
            2'd1: e.res = {32'hFFFFFFFF, sg, 8'hFF, 23'h000000};
            2'd2: e.res = {32'hFFFFFFFF, sg, 31'h0};
            default: begin e.res = {32'hFFFFFFFF, sg, 8'hFE, 23'h7FFFFF}; e.st = 5'b00101; end
        endcase
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic put(logic v, logic [1:0] k, logic us, logic s, logic [3:0] t);
        in_valid = v;
        kind     = k;
        use_sign = us;
        sign     = s;
        tag      = t;
    endtask

    // One cycle: record an accept at the negedge, return #1 after the next posedge.
    task automatic tick(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) sb.push_back(model(kind, use_sign, sign, tag));
        @(posedge clk);
        #1;
    endtask

    // Every presented result (stalled or not) must match the oldest expected entry.
    always @(negedge clk) begin
        if (mon_en && rst_n && out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", out_valid, 1'b0);
            end else begin
                chk("result", result, sb[0].res);
                chk("status", status, sb[0].st);
                chk("tag", tag_out, sb[0].tg);
                if (out_ready) begin
                    void'(sb.pop_front());
                    out_cnt++;
                end
            end
        end
    end

    initial begin
        bit acc;
        int sent;
        int base;
        int bound;
        logic [1:0] skind [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0};
        bit         rpat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

        flush = 0; out_ready = 1;
        put(0, 2'd0, 0, 0, 4'h0);
        d_flush = 0; d_in_valid = 0; d_out_ready = 1; d_kind = 0; d_use_sign = 0;
        d_sign = 0; d_tag = 0;

        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 64'h0);
        chk("rst_status", status, 5'h0);
        chk("rst_tag", tag_out, 4'h0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1; mon_en = 1;

        // NaN ignores the requested sign; two register stages of latency
        put(1, 2'd0, 1, 1, 4'h1);
        tick(acc);
        chk("nan_accept", acc, 1);
        put(0, 2'd0, 0, 0, 4'h0);
        @(negedge clk);
        chk("nan_lat_early", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("nan_lat_valid", out_valid, 1);
        chk("nan_literal", result, 64'hFFFFFFFF_7FC00000);
        chk("nan_status", status, 5'b10000);
        @(posedge clk); #1;

        // Inf/Zero/MaxNorm variants back to back
        put(1, 2'd1, 1, 1, 4'h2); tick(acc);
        put(1, 2'd1, 0, 1, 4'h3); tick(acc);
        put(1, 2'd2, 1, 1, 4'h4); tick(acc);
        put(1, 2'd3, 1, 1, 4'h5); tick(acc);
        put(0, 2'd0, 0, 0, 4'h0);
        for (int i = 0; i < 4; i++) tick(acc);
        chk("variants_drained", sb.size(), 0);

        // 8 tagged ops with out_ready cycling 1,0,0,1
        sent = 0;
        for (int c = 0; c < 64 && sent < 8; c++) begin
            out_ready = rpat[c % 4];
            put(1, skind[sent], 1, sent[0], 4'(sent + 8));
            tick(acc);
            if (acc) sent++;
        end
        chk("stream_sent", sent, 8);
        put(0, 2'd0, 0, 0, 4'h0);
        out_ready = 1;
        bound = 0;
        while (sb.size() != 0 && bound < 20) begin
            tick(acc);
            bound++;
        end
        chk("stream_drained", sb.size(), 0);

        // Full throughput: one accept and one result per cycle
        base = out_cnt;
        for (int i = 0; i < 8; i++) begin
            put(1, 2'(i % 4), 1, i[0], 4'(i));
            tick(acc);
            chk("tput_accept", acc, 1);
        end
        chk("tput_results", out_cnt - base, 6);
        put(0, 2'd0, 0, 0, 4'h0);
        for (int i = 0; i < 3; i++) tick(acc);
        chk("tput_drained", sb.size(), 0);

        // Fill with downstream stalled, then flush
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            put(1, 2'd2, 1, 1, 4'(i));
            tick(acc);
        end
        chk("fill_busy", busy, 1);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_count", sb.size(), 2);
        out_ready = 1;
        put(1, 2'd1, 1, 0, 4'hF);
        flush = 1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 0;
        put(0, 2'd0, 0, 0, 4'h0);
        sb.delete();
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) tick(acc);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            put(1, 2'd3, 1, 1, 4'(i + 3));
            tick(acc);
        end
        #1;
        rst_n = 0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_result", result, 64'h0);
        chk("arst_status", status, 5'h0);
        chk("arst_tag", tag_out, 4'h0);
        chk("arst_busy", busy, 0);
        sb.delete();
        put(0, 2'd0, 0, 0, 4'h0);
        @(posedge clk); #1;
        rst_n = 1;
        put(1, 2'd1, 1, 0, 4'hA);
        tick(acc);
        chk("arst_inf_accept", acc, 1);
        put(0, 2'd0, 0, 0, 4'h0);
        @(negedge clk);
        chk("arst_lat_early", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("arst_lat_valid", out_valid, 1);
        chk("arst_inf_literal", result, 64'hFFFFFFFF_7F800000);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) tick(acc);
        chk("final_empty", sb.size(), 0);

        // Combinational double-precision instance
        d_in_valid = 1; d_kind = 2'd3; d_use_sign = 0; d_sign = 0; d_tag = 4'h6;
        #1;
        chk("dp_maxnorm", d_result, 64'h7FEFFFFFFFFFFFFF);
        chk("dp_maxnorm_status", d_status, 5'b00101);
        chk("dp_out_valid", d_out_valid, 1);
        chk("dp_in_ready", d_in_ready, 1);
        chk("dp_tag", d_tag_out, 4'h6);
        d_kind = 2'd0; d_use_sign = 1; d_sign = 1;
        #1;
        chk("dp_nan", d_result, 64'h7FF8000000000000);
        chk("dp_nan_status", d_status, 5'b10000);
        d_out_ready = 0;
        #1;
        chk("dp_stall_ready", d_in_ready, 0);
        d_out_ready = 1; d_flush = 1;
        #1;
        chk("dp_flush_valid", d_out_valid, 0);
        chk("dp_flush_ready", d_in_ready, 0);
        chk("dp_busy", d_busy, 0);
        d_flush = 0; d_in_valid = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
